onchip_memory_arbiter: RTL

ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

---
 rtl/onchip_memory_arbiter_pkg.sv | 25 ++
 rtl/onchip_memory_arbiter_grant.sv | 39 +++
 rtl/onchip_memory_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared definitions for the on-chip memory arbiter.
// Holds the port-id encoding, the grant-type encoding used between the
// grant decision logic and the datapath, and a helper that sizes the
// m0 wait counter.
package onchip_memory_arbiter_pkg;

    // Identifies which master owns a pending read or won the last tie
    typedef enum logic {
        PORT_M0 = 1'b0,
        PORT_M1 = 1'b1
    } port_id_e;

    // Result of the per-cycle arbitration
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_M0   = 2'd1,
        GRANT_M1   = 2'd2
    } grant_e;

    // Bits needed to count 0..max_wait inclusive; never narrower than 1 bit
    function automatic int wait_cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/onchip_memory_arbiter_grant.sv
// Grant decision for the on-chip memory arbiter.
// Purely combinational: picks at most one of the two requesting masters.
// Ports:
//   req_m0, req_m1  - master is requesting (read or write high)
//   last_grant      - master that won the most recent actual grant
//   wait_count      - cycles m0 has been denied in a row (saturating)
//   grant           - GRANT_NONE / GRANT_M0 / GRANT_M1 for this cycle
module onchip_memory_arbiter_grant
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int PRIO_M1  = 1,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic              req_m0,
    input  logic              req_m1,
    input  port_id_e          last_grant,
    input  logic [WAIT_W-1:0] wait_count,
    output grant_e            grant
);

    // A contested cycle goes either to m1 (fixed priority, unless m0 has
    // waited the full budget) or to whichever master did not win last time.
    always_comb begin
        grant = GRANT_NONE;
        if (req_m0 && req_m1) begin
            if (PRIO_M1 != 0) begin
                grant = (wait_count == WAIT_W'(MAX_WAIT)) ? GRANT_M0 : GRANT_M1;
            end else begin
                grant = (last_grant == PORT_M1) ? GRANT_M0 : GRANT_M1;
            end
        end else if (req_m0) begin
            grant = GRANT_M0;
        end else if (req_m1) begin
            grant = GRANT_M1;
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM with a one-cycle
// read latency. m0 is the CPU side, m1 the audio sample DMA side.
// Ports:
//   clk, reset              - single clock, synchronous active-high reset
//   m0_* / m1_*             - Avalon-style slave ports (read, write, address,
//                             byteenable, writedata, waitrequest, readdata,
//                             readdatavalid)
//   mem_*                   - RAM side: address, byteenable, chipselect,
//                             write, writedata, clken, readdata (q)
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int PRIO_M1  = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int WAIT_W = wait_cnt_width(MAX_WAIT);

    logic              m0_req;
    logic              m1_req;
    logic              sel_m1;
    logic              granted_write;
    grant_e            grant;

    port_id_e          last_grant_q, last_grant_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic              rd_pend_q,    rd_pend_d;
    port_id_e          rd_port_q,    rd_port_d;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    onchip_memory_arbiter_grant #(
        .PRIO_M1  (PRIO_M1),
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_grant (
        .req_m0     (m0_req),
        .req_m1     (m1_req),
        .last_grant (last_grant_q),
        .wait_count (wait_cnt_q),
        .grant      (grant)
    );

    // RAM-side mux: with no grant the mux rests on m0, but chipselect and
    // write are low so those values never reach the RAM.
    always_comb begin
        sel_m1         = (grant == GRANT_M1);
        granted_write  = sel_m1 ? m1_write : m0_write;
        mem_address    = sel_m1 ? m1_address    : m0_address;
        mem_byteenable = sel_m1 ? m1_byteenable : m0_byteenable;
        mem_writedata  = sel_m1 ? m1_writedata  : m0_writedata;
        mem_chipselect = !reset && (grant != GRANT_NONE);
        mem_write      = mem_chipselect && granted_write;
        mem_clken      = !reset;
    end

    // Master-side handshake. Read data is shared; only the valid strobe
    // tells the masters apart.
    always_comb begin
        m0_waitrequest   = reset || (m0_req && (grant != GRANT_M0));
        m1_waitrequest   = reset || (m1_req && (grant != GRANT_M1));
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = !reset && rd_pend_q && (rd_port_q == PORT_M0);
        m1_readdatavalid = !reset && rd_pend_q && (rd_port_q == PORT_M1);
    end

    // Next state: remember the winner, age m0's denial count, and note a
    // granted read (write wins when both strobes are high) for next cycle.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant == GRANT_M0) begin
            last_grant_d = PORT_M0;
        end else if (grant == GRANT_M1) begin
            last_grant_d = PORT_M1;
        end

        wait_cnt_d = '0;
        if (m0_req && (grant != GRANT_M0)) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q
                                                           : wait_cnt_q + 1'b1;
        end

        rd_pend_d = (grant != GRANT_NONE) && !granted_write;
        rd_port_d = sel_m1 ? PORT_M1 : PORT_M0;
    end

    // A read granted in the same cycle reset is sampled is discarded here.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_M1;
            wait_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_port_q    <= PORT_M0;
        end else begin
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
        end
    end

endmodule
